io_port_responder: RTL and testbench

- Responder end of the core's I/O request/acknowledge interface: a four-register I/O device.
- Services the core's read and write channels independently.
- Bridges them to two external valid/ready streams through an input FIFO and an output FIFO.
- Also provides a status register and a loadable free-running cycle counter.
- Instantiated alongside the core in a system top level, in place of or next to other I/O devices.

---
 rtl/io_port_responder.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_io_port_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// io_port_responder: four-register I/O device on the core's req/ack read and write channels.
// Latency: an immediately serviceable access is acked one cycle after the request is seen (2 cycles per transaction).
// Backpressure: a read of an empty input FIFO or a write to a full output FIFO stalls (no ack) until serviceable.
//
// Ports:
//   clk, reset_i                    single clock, asynchronous active-low reset
//   read_req_i/read_addr_i          core read request (level) and address
//   dout_o/read_ack_o               registered read data and one-cycle read acknowledge
//   write_req_i/write_addr_i/din_i  core write request (level), address and data
//   write_ack_o                     one-cycle write acknowledge
//   ext_in_*                        external valid/ready stream into the input FIFO
//   ext_out_*                       external valid/ready stream out of the output FIFO
//
// Register map: 0x0 input FIFO pop (read) | 0x1 status (read) | 0x2 output FIFO push (write)
//               0x3 cycle counter (read value / write load). Everything else reads 0, writes are dropped.

// Generic synchronous FIFO: head is visible combinationally, push/pop are
// ignored when full/empty respectively, both may happen in one cycle.
module io_port_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap mod DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module io_port_responder #(
  parameter int D_WIDTH  = 34,
  parameter int PA_WIDTH = 4,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                read_req_i,
  input  logic [PA_WIDTH-1:0] read_addr_i,
  output logic [D_WIDTH-1:0]  dout_o,
  output logic                read_ack_o,
  input  logic                write_req_i,
  input  logic [PA_WIDTH-1:0] write_addr_i,
  input  logic [D_WIDTH-1:0]  din_i,
  output logic                write_ack_o,
  input  logic [D_WIDTH-1:0]  ext_in_data_i,
  input  logic                ext_in_valid_i,
  output logic                ext_in_ready_o,
  output logic [D_WIDTH-1:0]  ext_out_data_o,
  output logic                ext_out_valid_o,
  input  logic                ext_out_ready_i
);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [PA_WIDTH-1:0] ADDR_FIFO   = PA_WIDTH'(0);
  localparam logic [PA_WIDTH-1:0] ADDR_STATUS = PA_WIDTH'(1);
  localparam logic [PA_WIDTH-1:0] ADDR_OUT    = PA_WIDTH'(2);
  localparam logic [PA_WIDTH-1:0] ADDR_CNT    = PA_WIDTH'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ACK   = 2'd2
  } state_t;

  // ---------------------------------------------------------------- FIFOs
  logic               in_full;
  logic               in_empty;
  logic [CW-1:0]      in_count;
  logic [D_WIDTH-1:0] in_head;
  logic               in_pop;

  logic               out_full;
  logic               out_empty;
  logic [CW-1:0]      out_count;
  logic               out_push;

  assign ext_in_ready_o  = !in_full;
  assign ext_out_valid_o = !out_empty;

  io_port_fifo #(.WIDTH(D_WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk      (clk),
    .rst_n    (reset_i),
    .push     (ext_in_valid_i && !in_full),
    .push_dat (ext_in_data_i),
    .pop      (in_pop),
    .head_dat (in_head),
    .full     (in_full),
    .empty    (in_empty),
    .count    (in_count)
  );

  io_port_fifo #(.WIDTH(D_WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk      (clk),
    .rst_n    (reset_i),
    .push     (out_push),
    .push_dat (din_i),
    .pop      (ext_out_ready_i && !out_empty),
    .head_dat (ext_out_data_o),
    .full     (out_full),
    .empty    (out_empty),
    .count    (out_count)
  );

  // ---------------------------------------------------------------- status
  logic [D_WIDTH-1:0] status;

  always_comb begin
    status            = '0;
    status[0]         = in_empty;
    status[1]         = out_full;
    status[2 +: CW]   = in_count;
    status[2+CW +: CW] = out_count;
  end

  // ---------------------------------------------------------------- counter
  logic [D_WIDTH-1:0] cnt;
  logic               cnt_load;

  // A load replaces this cycle's increment, but the loaded value still
  // counts the load cycle itself, so the register takes din_i + 1.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      cnt <= '0;
    end else if (cnt_load) begin
      cnt <= din_i + D_WIDTH'(1);
    end else begin
      cnt <= cnt + D_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------- read FSM
  state_t             rd_state;
  state_t             rd_state_nxt;
  logic               rd_ok;
  logic               rd_capture;
  logic [D_WIDTH-1:0] rd_data;

  // Empty is sampled this cycle, so a push landing on the same edge is only
  // seen by the pop one cycle later.
  assign rd_ok = (read_addr_i != ADDR_FIFO) || !in_empty;

  always_comb begin
    rd_data = '0;
    case (read_addr_i)
      ADDR_FIFO:   rd_data = in_head;
      ADDR_STATUS: rd_data = status;
      ADDR_CNT:    rd_data = cnt;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rd_state <= IDLE;
    end else begin
      rd_state <= rd_state_nxt;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_capture   = 1'b0;
    case (rd_state)
      IDLE, STALL: begin
        if (read_req_i) begin
          if (rd_ok) begin
            rd_capture   = 1'b1;
            rd_state_nxt = ACK;
          end else begin
            rd_state_nxt = STALL;
          end
        end else begin
          rd_state_nxt = IDLE;
        end
      end
      // The request is still high during the ack cycle; it is ignored here.
      ACK:     rd_state_nxt = IDLE;
      default: rd_state_nxt = IDLE;
    endcase
  end

  assign in_pop     = rd_capture && (read_addr_i == ADDR_FIFO);
  assign read_ack_o = (rd_state == ACK);

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      dout_o <= '0;
    end else if (rd_capture) begin
      dout_o <= rd_data;
    end
  end

  // ---------------------------------------------------------------- write FSM
  state_t wr_state;
  state_t wr_state_nxt;
  logic   wr_ok;
  logic   wr_commit;

  // Full is sampled this cycle, so an external pop on the same edge does not
  // unblock the push until the following cycle.
  assign wr_ok = !((write_addr_i == ADDR_OUT) && out_full);

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      wr_state <= IDLE;
    end else begin
      wr_state <= wr_state_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_commit    = 1'b0;
    case (wr_state)
      IDLE, STALL: begin
        if (write_req_i) begin
          if (wr_ok) begin
            wr_commit    = 1'b1;
            wr_state_nxt = ACK;
          end else begin
            wr_state_nxt = STALL;
          end
        end else begin
          wr_state_nxt = IDLE;
        end
      end
      ACK:     wr_state_nxt = IDLE;
      default: wr_state_nxt = IDLE;
    endcase
  end

  assign out_push    = wr_commit && (write_addr_i == ADDR_OUT);
  assign cnt_load    = wr_commit && (write_addr_i == ADDR_CNT);
  assign write_ack_o = (wr_state == ACK);
endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: drives the core channels and both
// streams cycle by cycle and checks every observation against hand-computed values.
module tb_io_port_responder;
  localparam int DW = 34;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          read_req_i = 1'b0;
  logic [AW-1:0] read_addr_i = '0;
  logic [DW-1:0] dout_o;
  logic          read_ack_o;
  logic          write_req_i = 1'b0;
  logic [AW-1:0] write_addr_i = '0;
  logic [DW-1:0] din_i = '0;
  logic          write_ack_o;
  logic [DW-1:0] ext_in_data_i = '0;
  logic          ext_in_valid_i = 1'b0;
  logic          ext_in_ready_o;
  logic [DW-1:0] ext_out_data_o;
  logic          ext_out_valid_o;
  logic          ext_out_ready_i = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [DW-1:0] CNT_NEAR_WRAP = 34'h3_FFFF_FFFE;

  always #5 clk = ~clk;

  io_port_responder #(.D_WIDTH(DW), .PA_WIDTH(AW), .DEPTH(8)) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .read_req_i      (read_req_i),
    .read_addr_i     (read_addr_i),
    .dout_o          (dout_o),
    .read_ack_o      (read_ack_o),
    .write_req_i     (write_req_i),
    .write_addr_i    (write_addr_i),
    .din_i           (din_i),
    .write_ack_o     (write_ack_o),
    .ext_in_data_i   (ext_in_data_i),
    .ext_in_valid_i  (ext_in_valid_i),
    .ext_in_ready_o  (ext_in_ready_o),
    .ext_out_data_o  (ext_out_data_o),
    .ext_out_valid_o (ext_out_valid_o),
    .ext_out_ready_i (ext_out_ready_i)
  );

  // Each call moves to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues a read, waits (bounded) for the ack, returns data and the number of
  // cycles from request to ack, and leaves the bench in the cycle after ack.
  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    read_req_i  = 1'b1;
    read_addr_i = a;
    d   = '0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (read_ack_o) begin
        d = dout_o;
        break;
      end
    end
    read_req_i = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
    write_req_i  = 1'b1;
    write_addr_i = a;
    din_i        = d;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (write_ack_o) break;
    end
    write_req_i = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    int            lat;
    logic [DW-1:0] seen [9];
    int            got;
    int            ack_at;

    // ---------------- reset state
    tick();
    tick();
    check("rst_read_ack", 64'(read_ack_o), 64'd0);
    check("rst_write_ack", 64'(write_ack_o), 64'd0);
    check("rst_dout", 64'(dout_o), 64'd0);
    check("rst_in_ready", 64'(ext_in_ready_o), 64'd1);
    check("rst_out_valid", 64'(ext_out_valid_o), 64'd0);
    reset_i = 1'b1;

    // Status read leaves a non-zero dout so the reset clear is visible.
    do_read(4'h1, d, lat);
    check("pre_status", 64'(d), 64'h1);

    // ---------------- reset mid-stall
    read_req_i  = 1'b1;
    read_addr_i = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_ack", 64'(read_ack_o), 64'd0);
    end
    reset_i    = 1'b0;
    read_req_i = 1'b0;
    #1;
    check("midrst_read_ack", 64'(read_ack_o), 64'd0);
    check("midrst_dout", 64'(dout_o), 64'd0);
    tick();
    tick();
    reset_i = 1'b1;
    // First cycle out of reset: counter still 0 when captured.
    do_read(4'h3, d, lat);
    check("rst_counter", 64'(d), 64'd0);
    check("rst_counter_lat", 64'(lat), 64'd1);
    do_read(4'h1, d, lat);
    check("rst_status", 64'(d), 64'h1);

    // ---------------- stream in
    ext_in_valid_i = 1'b1;
    ext_in_data_i  = 34'h11;
    check("in_ready", 64'(ext_in_ready_o), 64'd1);
    tick();
    ext_in_data_i = 34'h22;
    tick();
    ext_in_data_i = 34'h33;
    tick();
    ext_in_valid_i = 1'b0;
    do_read(4'h1, d, lat);
    check("status_in3", 64'(d), 64'hC);
    do_read(4'h0, d, lat);
    check("pop0", 64'(d), 64'h11);
    check("pop0_lat", 64'(lat), 64'd1);
    do_read(4'h0, d, lat);
    check("pop1", 64'(d), 64'h22);
    check("pop1_lat", 64'(lat), 64'd1);
    do_read(4'h0, d, lat);
    check("pop2", 64'(d), 64'h33);
    check("pop2_lat", 64'(lat), 64'd1);
    do_read(4'h1, d, lat);
    check("status_in0", 64'(d), 64'h1);

    // Unmapped / write-only reads return 0; no-effect writes still ack.
    do_read(4'h2, d, lat);
    check("read_addr2", 64'(d), 64'd0);
    do_read(4'hF, d, lat);
    check("read_addrF", 64'(d), 64'd0);
    do_write(4'h0, 34'h5, lat);
    check("write_addr0_lat", 64'(lat), 64'd1);
    do_write(4'h1, 34'h5, lat);
    check("write_addr1_lat", 64'(lat), 64'd1);

    // ---------------- empty stall
    read_req_i  = 1'b1;
    read_addr_i = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("empty_wait", 64'(read_ack_o), 64'd0);
    end
    ext_in_valid_i = 1'b1;
    ext_in_data_i  = 34'h2A;
    tick();
    ext_in_valid_i = 1'b0;
    check("empty_ack_early", 64'(read_ack_o), 64'd0);
    tick();
    check("empty_ack", 64'(read_ack_o), 64'd1);
    check("empty_data", 64'(dout_o), 64'h2A);
    read_req_i = 1'b0;
    tick();

    // ---------------- full stall
    ext_out_ready_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      do_write(4'h2, DW'(k), lat);
      check("fill_lat", 64'(lat), 64'd1);
    end
    write_req_i  = 1'b1;
    write_addr_i = 4'h2;
    din_i        = 34'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_no_ack", 64'(write_ack_o), 64'd0);
    end
    do_read(4'h1, d, lat);
    check("status_full", 64'(d), 64'h203);
    ext_out_ready_i = 1'b1;
    got    = 0;
    ack_at = -1;
    for (int i = 0; i < 30; i++) begin
      if (ext_out_valid_o && got < 9) begin
        seen[got] = ext_out_data_o;
        got++;
      end
      if (write_ack_o && ack_at < 0) begin
        ack_at      = i;
        write_req_i = 1'b0;
      end
      tick();
    end
    check("full_ack_cycle", 64'(ack_at), 64'd2);
    check("out_count", 64'(got), 64'd9);
    for (int k = 0; k < 9; k++) begin
      check("out_data", 64'(seen[k]), 64'(k + 1));
    end
    check("out_drained", 64'(ext_out_valid_o), 64'd0);
    ext_out_ready_i = 1'b0;

    // ---------------- counter load / wrap
    write_req_i  = 1'b1;
    write_addr_i = 4'h3;
    din_i        = CNT_NEAR_WRAP;
    tick();
    check("load_ack", 64'(write_ack_o), 64'd1);
    write_req_i = 1'b0;
    read_req_i  = 1'b1;
    read_addr_i = 4'h3;
    tick();
    check("cnt_ack", 64'(read_ack_o), 64'd1);
    check("cnt_max", 64'(dout_o), 64'h3_FFFF_FFFF);
    read_req_i = 1'b0;
    tick();
    read_req_i = 1'b1;
    tick();
    check("cnt_wrapped", 64'(dout_o), 64'd1);
    read_req_i = 1'b0;
    tick();

    write_req_i = 1'b1;
    din_i       = CNT_NEAR_WRAP;
    tick();
    write_req_i = 1'b0;
    tick();
    // Concurrent read and load on the same edge: read sees the old value (0).
    write_req_i = 1'b1;
    din_i       = 34'd5;
    read_req_i  = 1'b1;
    read_addr_i = 4'h3;
    tick();
    check("conc_load_wack", 64'(write_ack_o), 64'd1);
    check("conc_load_rack", 64'(read_ack_o), 64'd1);
    check("cnt_zero_old", 64'(dout_o), 64'd0);
    write_req_i = 1'b0;
    read_req_i  = 1'b0;
    tick();
    read_req_i = 1'b1;
    tick();
    check("cnt_after_load", 64'(dout_o), 64'd7);
    read_req_i = 1'b0;
    tick();

    // ---------------- concurrent traffic
    read_req_i   = 1'b1;
    read_addr_i  = 4'h1;
    write_req_i  = 1'b1;
    write_addr_i = 4'h7;
    din_i        = 34'h1_2345_6789;
    tick();
    check("conc_rack", 64'(read_ack_o), 64'd1);
    check("conc_wack", 64'(write_ack_o), 64'd1);
    check("conc_status", 64'(dout_o), 64'h1);
    read_req_i  = 1'b0;
    write_req_i = 1'b0;
    tick();
    check("conc_rack_pulse", 64'(read_ack_o), 64'd0);
    check("conc_wack_pulse", 64'(write_ack_o), 64'd0);
    check("conc_no_out", 64'(ext_out_valid_o), 64'd0);
    do_read(4'h1, d, lat);
    check("conc_status_after", 64'(d), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
